// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the bit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A one-bit operand still needs a one-bit counter to hold its single index.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/full_adder_bit.sv
// Combinational one-bit sum/carry cell; the serial adder reuses a single
// instance of it for every bit position.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic r_in,
    output logic s,
    output logic r_out
);

    assign s     = a ^ b ^ r_in;
    assign r_out = (a & b) | (a & r_in) | (b & r_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: operands are shifted LSB-first through one
// full-adder cell, with the carry registered between bits.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         r_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         r_out,
    output logic         overflow
);

    localparam int            CW   = cntWidth(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e         state_q, state_d;
    logic [N-1:0]   shA_q, shA_d;
    logic [N-1:0]   shB_q, shB_d;
    logic [N-1:0]   shS_q, shS_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   s_q, s_d;
    logic           rOut_q, rOut_d;
    logic           ovf_q, ovf_d;

    logic           faSum;
    logic           faCarry;
    logic [N-1:0]   shiftedS;

    full_adder_bit u_fa (
        .a     (shA_q[0]),
        .b     (shB_q[0]),
        .r_in  (carry_q),
        .s     (faSum),
        .r_out (faCarry)
    );

    // The new sum bit enters at the MSB so that after N bits it lands at bit 0.
    if (N == 1) begin : g_single
        assign shiftedS = faSum;
    end else begin : g_multi
        assign shiftedS = {faSum, shS_q[N-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shA_q   <= '0;
            shB_q   <= '0;
            shS_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            rOut_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shA_q   <= shA_d;
            shB_q   <= shB_d;
            shS_q   <= shS_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            rOut_q  <= rOut_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shA_d   = shA_q;
        shB_d   = shB_q;
        shS_d   = shS_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        rOut_d  = rOut_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    shA_d   = a;
                    shB_d   = b;
                    carry_d = r_in;
                    cnt_d   = '0;
                    shS_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                shA_d   = shA_q >> 1;
                shB_d   = shB_q >> 1;
                shS_d   = shiftedS;
                carry_d = faCarry;
                // Signed overflow is the carry into the MSB differing from the carry out.
                if (cnt_q == LAST) begin
                    s_d     = shiftedS;
                    rOut_d  = faCarry;
                    ovf_d   = carry_q ^ faCarry;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign s        = s_q;
    assign r_out    = rOut_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at widths 8, 4 and 1 against an
// arithmetic reference model of unsigned add with signed-overflow flag.
module tb_serial_adder;

    logic       clk;
    logic       rst;

    logic       start8, start4, start1;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       a1, b1;
    logic       cin8, cin4, cin1;
    logic       busy8, busy4, busy1;
    logic       done8, done4, done1;
    logic [7:0] s8;
    logic [3:0] s4;
    logic       s1;
    logic       rout8, rout4, rout1;
    logic       ovf8, ovf4, ovf1;

    int vectors;
    int miscompares;

    serial_adder #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .r_in(cin8),
        .busy(busy8), .done(done8), .s(s8), .r_out(rout8), .overflow(ovf8)
    );

    serial_adder #(.N(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .r_in(cin4),
        .busy(busy4), .done(done4), .s(s4), .r_out(rout4), .overflow(ovf4)
    );

    serial_adder #(.N(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .r_in(cin1),
        .busy(busy1), .done(done1), .s(s1), .r_out(rout1), .overflow(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {overflow, r_out, s[7:0]} from plain integer arithmetic.
    function automatic logic [9:0] modelAdd(input int w, input logic [7:0] av, input logic [7:0] bv,
                                            input logic cin);
        int unsigned ua, ub, total, mask;
        int sa, sb, stotal, half;
        logic [9:0] r;
        mask   = (32'd1 << w) - 1;
        half   = 1 << (w - 1);
        ua     = 32'(av) & mask;
        ub     = 32'(bv) & mask;
        total  = ua + ub + 32'(cin);
        sa     = (ua >= 32'(half)) ? int'(ua) - (1 << w) : int'(ua);
        sb     = (ub >= 32'(half)) ? int'(ub) - (1 << w) : int'(ub);
        stotal = sa + sb + int'(cin);
        r      = '0;
        r[7:0] = 8'(total & mask);
        r[8]   = ((total >> w) & 32'd1) != 0;
        r[9]   = (stotal > half - 1) || (stotal < -half);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int w, input logic [7:0] av, input logic [7:0] bv,
                                 input logic cin, input logic st);
        start8 = 1'b0;
        start4 = 1'b0;
        start1 = 1'b0;
        case (w)
            8: begin a8 = av;      b8 = bv;      cin8 = cin; start8 = st; end
            4: begin a4 = av[3:0]; b4 = bv[3:0]; cin4 = cin; start4 = st; end
            default: begin a1 = av[0]; b1 = bv[0]; cin1 = cin; start1 = st; end
        endcase
    endtask

    task automatic sampleOutputs(input int w, output logic bsy, output logic dn, output logic [7:0] sv,
                                 output logic rv, output logic ov);
        case (w)
            8: begin bsy = busy8; dn = done8; sv = s8;        rv = rout8; ov = ovf8; end
            4: begin bsy = busy4; dn = done4; sv = 8'(s4);    rv = rout4; ov = ovf4; end
            default: begin bsy = busy1; dn = done1; sv = 8'(s1); rv = rout1; ov = ovf1; end
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One full operation: start pulse, bounded wait for done, result and pulse-width checks.
    task automatic runOp(input int w, input logic [7:0] av, input logic [7:0] bv, input logic cin,
                         input string tag);
        logic [9:0] expv;
        logic       bsy, dn, rv, ov;
        logic [7:0] sv;
        int         cycles;
        expv = modelAdd(w, av, bv, cin);
        applyStimulus(w, av, bv, cin, 1'b1);
        tick();
        applyStimulus(w, av, bv, cin, 1'b0);
        sampleOutputs(w, bsy, dn, sv, rv, ov);
        checkOutput({tag, ".busy"}, 32'(bsy), 32'd1);
        cycles = 0;
        dn     = 1'b0;
        while (!dn && cycles < 4 * w + 4) begin
            tick();
            cycles++;
            sampleOutputs(w, bsy, dn, sv, rv, ov);
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(w));
        checkOutput({tag, ".s"}, 32'(sv), 32'(expv[7:0]));
        checkOutput({tag, ".r_out"}, 32'(rv), 32'(expv[8]));
        checkOutput({tag, ".overflow"}, 32'(ov), 32'(expv[9]));
        tick();
        sampleOutputs(w, bsy, dn, sv, rv, ov);
        checkOutput({tag, ".donePulse"}, {30'd0, dn, bsy}, 32'd0);
    endtask

    initial begin
        logic       bsy, dn, rv, ov;
        logic [7:0] sv;
        logic [9:0] expv;
        int         cycles;
        int         donesSeen;
        logic [7:0] ra, rb;
        logic       rc;

        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        applyStimulus(8, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(4, 8'h00, 8'h00, 1'b0, 1'b0);
        applyStimulus(1, 8'h00, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        sampleOutputs(8, bsy, dn, sv, rv, ov);
        checkOutput("reset8", {24'd0, sv}, 32'd0);
        checkOutput("reset8.flags", {28'd0, bsy, dn, rv, ov}, 32'd0);
        sampleOutputs(4, bsy, dn, sv, rv, ov);
        checkOutput("reset4", {20'd0, bsy, dn, rv, ov, sv}, 32'd0);
        sampleOutputs(1, bsy, dn, sv, rv, ov);
        checkOutput("reset1", {20'd0, bsy, dn, rv, ov, sv}, 32'd0);
        rst = 1'b0;
        tick();

        runOp(8, 8'h0F, 8'h01, 1'b0, "p1");
        runOp(8, 8'hFF, 8'h01, 1'b0, "p2");
        runOp(8, 8'h7F, 8'h01, 1'b0, "p3a");
        runOp(8, 8'h80, 8'h80, 1'b0, "p3b");
        runOp(8, 8'hFF, 8'hFF, 1'b1, "p4");
        runOp(1, 8'h01, 8'h01, 1'b1, "n1");
        runOp(1, 8'h01, 8'h00, 1'b0, "n1b");

        // Start held high through RUN/DONE with operands changing every cycle.
        applyStimulus(8, 8'h12, 8'h34, 1'b0, 1'b1);
        tick();
        sampleOutputs(8, bsy, dn, sv, rv, ov);
        checkOutput("hold.busy", 32'(bsy), 32'd1);
        cycles = 0;
        dn     = 1'b0;
        while (!dn && cycles < 40) begin
            applyStimulus(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
            tick();
            cycles++;
            sampleOutputs(8, bsy, dn, sv, rv, ov);
        end
        checkOutput("hold.latency", 32'(cycles), 32'd8);
        checkOutput("hold.s", 32'(sv), 32'h46);
        applyStimulus(8, 8'h99, 8'h22, 1'b1, 1'b1);
        tick();
        sampleOutputs(8, bsy, dn, sv, rv, ov);
        checkOutput("b2b.idleBusy", 32'(bsy), 32'd0);
        checkOutput("b2b.idleS", 32'(sv), 32'h46);
        tick();
        applyStimulus(8, 8'h99, 8'h22, 1'b1, 1'b0);
        sampleOutputs(8, bsy, dn, sv, rv, ov);
        checkOutput("b2b.busy", 32'(bsy), 32'd1);
        expv   = modelAdd(8, 8'h99, 8'h22, 1'b1);
        cycles = 0;
        dn     = 1'b0;
        while (!dn && cycles < 40) begin
            checkOutput("b2b.holdS", 32'(sv), 32'h46);
            tick();
            cycles++;
            sampleOutputs(8, bsy, dn, sv, rv, ov);
        end
        checkOutput("b2b.latency", 32'(cycles), 32'd8);
        checkOutput("b2b.s", 32'(sv), 32'(expv[7:0]));
        checkOutput("b2b.flags", {30'd0, rv, ov}, {30'd0, expv[8], expv[9]});
        tick();

        // Abort mid-operation with a synchronous reset.
        applyStimulus(8, 8'hAA, 8'h55, 1'b0, 1'b1);
        tick();
        applyStimulus(8, 8'hAA, 8'h55, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sampleOutputs(8, bsy, dn, sv, rv, ov);
        checkOutput("abort.busy", 32'(bsy), 32'd0);
        checkOutput("abort.s", 32'(sv), 32'd0);
        checkOutput("abort.flags", {29'd0, dn, rv, ov}, 32'd0);
        donesSeen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done8 === 1'b1) donesSeen++;
        end
        checkOutput("abort.noDone", 32'(donesSeen), 32'd0);
        runOp(8, 8'h01, 8'h02, 1'b0, "p6");

        for (int i = 0; i < 24; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            runOp(8, ra, rb, rc, "rand8");
        end

        for (int i = 0; i < 512; i++) begin
            runOp(4, 8'(i & 15), 8'((i >> 4) & 15), 1'((i >> 8) & 1), "exh4");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder built around a single one-bit full-adder cell.
- Operands are loaded into shift registers and fed LSB-first, one bit per clock, into the cell.
- Carry out is registered and fed back as the next bit's carry in.
- Sits directly downstream of the one-bit sum/carry cell: it consumes that cell's s/r_out each cycle and assembles the N-bit result, trading N cycles of latency for one adder cell.

Parameters:
- N, 8, operand/result width in bits (N >= 1).

Ports:
- clk, in, 1, single clock; all state updates on rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, request; sampled only in IDLE.
- a, in, N, operand A; captured on accepted start.
- b, in, N, operand B; captured on accepted start.
- r_in, in, 1, initial carry in; captured on accepted start.
- busy, out, 1, high while state != IDLE.
- done, out, 1, one-cycle pulse; result valid.
- s, out, N, registered sum.
- r_out, out, 1, registered carry out of MSB.
- overflow, out, 1, registered signed overflow.

Behaviour:
- Interface: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, s=0, r_out=0, overflow=0; shift regs, carry FF and bit counter cleared.
- Reset mid-operation aborts the add: no done pulse, outputs return to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> sh_a<=a, sh_b<=b, carry<=r_in, cnt<=0, sh_s<=0; go RUN.
  - start=0 -> stay.
- RUN (each edge):
  - bit = sh_a[0]^sh_b[0]^carry.
  - carry <= majority(sh_a[0], sh_b[0], carry).
  - sh_s <= {bit, sh_s[N-1:1]}.
  - sh_a and sh_b shift right, zero-filled; cnt<=cnt+1.
  - When cnt==N-1 (last bit), the same edge also writes:
    - s<={bit, sh_s[N-1:1]}
    - r_out<=carry_next
    - overflow<=carry ^ carry_next (carry into MSB xor carry out of MSB)
    - then go DONE.
- DONE: done=1 for exactly one cycle; go IDLE unconditionally.
- Latency: done is high in the cycle following the N-th edge after the edge that accepted start. Total RUN cycles = N; N=1 gives one RUN cycle.
- start while busy (RUN or DONE) is ignored; operands are not re-captured. start in the first IDLE cycle after DONE is accepted (back-to-back ops).
- s, r_out and overflow hold their values from completion until the next completion or reset. They are not disturbed while a new op runs.
- Counter width: $clog2(N) bits, minimum 1. No wrap beyond N-1 is ever reached.
- Arithmetic: unsigned N-bit add with carry in. No truncation other than the carry out going to r_out.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams/constants; counter-width helper.
- One natural sub-module: full_adder_bit. It is a purely combinational one-bit sum/carry cell (s, r_out from a, b, r_in) instantiated once.
- serial_adder holds the FSM, shift registers, carry FF, counter and result registers.

Test Plan:
1. N=8, a=0x0F, b=0x01, r_in=0, start pulse -> busy next cycle; done exactly 8 edges later; s=0x10, r_out=0, overflow=0.
2. a=0xFF, b=0x01, r_in=0 -> s=0x00, r_out=1, overflow=0.
3. a=0x7F, b=0x01, r_in=0 -> s=0x80, r_out=0, overflow=1. Also a=0x80, b=0x80 -> s=0x00, r_out=1, overflow=1.
4. a=0xFF, b=0xFF, r_in=1 -> s=0xFF, r_out=1, overflow=0. Then N=1, a=1, b=1, r_in=1 -> s=1, r_out=1, done 1 edge after start.
5. start held high with changing operands during RUN/DONE -> only first op computed. Start in the first IDLE cycle after done -> second result correct, s holds first result until second done.
6. rst asserted at bit 3 of a=0xAA, b=0x55 -> next cycle busy=0, s=0, no done pulse. Subsequent a=0x01, b=0x02 -> s=0x03. Also N=4 exhaustive a, b, r_in vs a+b+r_in.
